// File: rtl/paced_pattern_gen.sv
// paced_pattern_gen: debounced pause/faster/slower buttons pace a WIDTH-bit pattern
// that rotates, bounces, counts in binary or counts in Gray code.
module paced_pattern_gen #(
    parameter int WIDTH           = 8,
    parameter int LEVELS          = 8,
    parameter int BASE_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      pause_btn,
    input  logic                      faster_btn,
    input  logic                      slower_btn,
    input  logic [1:0]                mode,
    output logic [WIDTH-1:0]          pattern,
    output logic                      running,
    output logic [$clog2(LEVELS)-1:0] speed,
    output logic                      step
);
    localparam int SW = $clog2(LEVELS);
    localparam int PW = $clog2(BASE_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [2:0]       btn, s1_q, s2_q, db_q, db_d, dbp_q, ev;
    logic             running_q, running_d, step_q, dir_q, dir_d;
    logic             up, dn, spd_chg, reload, at_end, adv;
    logic [SW-1:0]    speed_q, speed_d;
    logic [PW-1:0]    pre_q, pre_d, last;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] pat_q, pat_d, bin_q, bin_d, rot, bnc;

    assign btn = {slower_btn, faster_btn, pause_btn};

    // Synchronisers keep sampling even while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn;
            s2_q <= s1_q;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [DW-1:0] cnt_q, cnt_d;
        logic          done;
        assign done    = cnt_q == DW'(DEBOUNCE_CYCLES - 1);
        assign db_d[i] = (s2_q[i] != db_q[i] && done) ? s2_q[i] : db_q[i];
        assign cnt_d   = (s2_q[i] == db_q[i] || done) ? '0 : cnt_q + 1'b1;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cnt_q <= '0;
            else if (ena)
                cnt_q <= cnt_d;
        end
    end

    assign ev = db_q & ~dbp_q;

    assign up        = ev[1] & ~ev[2] & (speed_q != SW'(LEVELS - 1));
    assign dn        = ev[2] & ~ev[1] & (speed_q != '0);
    assign spd_chg   = up | dn;
    assign speed_d   = up ? speed_q + 1'b1 : dn ? speed_q - 1'b1 : speed_q;
    assign running_d = running_q ^ ev[0];

    assign reload = mode_q != mode;
    assign last   = PW'((BASE_DIV >> speed_q) - 1);
    assign at_end = pre_q == last;
    assign adv    = running_q & at_end & ~reload & ~spd_chg;
    assign pre_d  = (reload | spd_chg) ? '0 : !running_q ? pre_q : at_end ? '0 : pre_q + 1'b1;

    assign rot = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
    assign bnc = dir_q ? pat_q >> 1 : pat_q << 1;

    // dir_q = 1 means the bouncing bit travels toward bit 0.
    always_comb begin
        pat_d = pat_q;
        bin_d = bin_q;
        dir_d = dir_q;
        if (reload) begin
            pat_d = mode[1] ? '0 : WIDTH'(1);
            bin_d = '0;
            dir_d = 1'b0;
        end else if (adv) begin
            bin_d = bin_q + 1'b1;
            pat_d = mode_q == 2'd0 ? rot : mode_q == 2'd1 ? bnc :
                    mode_q == 2'd2 ? bin_d : bin_d ^ (bin_d >> 1);
            dir_d = mode_q == 2'd1 ? (bnc[WIDTH-1] | (dir_q & ~bnc[0])) : dir_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q      <= '0;
            dbp_q     <= '0;
            running_q <= 1'b0;
            speed_q   <= '0;
            pre_q     <= '0;
            mode_q    <= '0;
            pat_q     <= WIDTH'(1);
            bin_q     <= '0;
            dir_q     <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            step_q <= ena & adv;
            if (ena) begin
                db_q      <= db_d;
                dbp_q     <= db_q;
                running_q <= running_d;
                speed_q   <= speed_d;
                pre_q     <= pre_d;
                mode_q    <= mode;
                pat_q     <= pat_d;
                bin_q     <= bin_d;
                dir_q     <= dir_d;
            end
        end
    end

    assign pattern = pat_q;
    assign running = running_q;
    assign speed   = speed_q;
    assign step    = step_q & ena;
endmodule

// File: tb/tb_paced_pattern_gen.sv
// tb_paced_pattern_gen: directed and random button/mode/enable stimulus checked each cycle
// against a step-count based reference model of the pattern generator.
module tb_paced_pattern_gen;
    localparam int W  = 4;
    localparam int L  = 4;
    localparam int BD = 16;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst_n, ena, pause_btn, faster_btn, slower_btn;
    logic [1:0]   mode;
    logic [W-1:0] pattern;
    logic         running, step;
    logic [1:0]   speed;

    int n_vec = 0;
    int n_err = 0;

    int m_s1[3], m_s2[3], m_db[3], m_dbp[3], m_run[3];
    int m_running, m_speed, m_pre, m_mode, m_k, m_step;

    paced_pattern_gen #(.WIDTH(W), .LEVELS(L), .BASE_DIV(BD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pause_btn(pause_btn), .faster_btn(faster_btn),
        .slower_btn(slower_btn), .mode(mode), .pattern(pattern), .running(running),
        .speed(speed), .step(step)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_dbp[b] = 0; m_run[b] = 0;
        end
        m_running = 0; m_speed = 0; m_pre = 0; m_mode = 0; m_k = 0; m_step = 0;
    endtask

    // Pattern is a pure function of the mode and the number of advances since the seed.
    function automatic int exp_pat();
        int pos, v;
        v = m_k % (1 << W);
        pos = m_k % (2 * (W - 1));
        case (m_mode)
            0: return 1 << (m_k % W);
            1: return 1 << (pos < W ? pos : 2 * (W - 1) - pos);
            2: return v;
            default: return v ^ (v >> 1);
        endcase
    endfunction

    task automatic model_step();
        int pin[3];
        int ev[3];
        int p;
        bit up, dn;
        pin[0] = int'(pause_btn); pin[1] = int'(faster_btn); pin[2] = int'(slower_btn);
        if (ena) begin
            for (int b = 0; b < 3; b++) begin
                ev[b] = (m_db[b] == 1 && m_dbp[b] == 0) ? 1 : 0;
                m_dbp[b] = m_db[b];
                if (m_s2[b] == m_db[b]) m_run[b] = 0;
                else if (m_run[b] == DB - 1) begin m_db[b] = m_s2[b]; m_run[b] = 0; end
                else m_run[b]++;
            end
            up = ev[1] == 1 && ev[2] == 0 && m_speed < L - 1;
            dn = ev[2] == 1 && ev[1] == 0 && m_speed > 0;
            p = BD >> m_speed;
            m_step = 0;
            if (m_mode != int'(mode)) begin
                m_k = 0; m_pre = 0;
            end else if (up || dn) begin
                m_pre = 0;
            end else if (m_running == 1) begin
                m_pre++;
                if (m_pre == p) begin m_pre = 0; m_k++; m_step = 1; end
            end
            m_running ^= ev[0];
            m_speed += int'(up) - int'(dn);
            m_mode = int'(mode);
        end else begin
            m_step = 0;
        end
        for (int b = 0; b < 3; b++) begin
            m_s2[b] = m_s1[b];
            m_s1[b] = pin[b];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        @(negedge clk);
        check("pat", 32'(pattern), exp_pat());
        check("run", 32'(running), m_running);
        check("spd", 32'(speed), m_speed);
        check("stp", 32'(step), (m_step == 1 && ena) ? 1 : 0);
    endtask

    task automatic set_pin(input int b, input logic v);
        if (b == 0) pause_btn = v;
        else if (b == 1) faster_btn = v;
        else slower_btn = v;
    endtask

    task automatic press(input int b, input int hold);
        set_pin(b, 1'b1);
        repeat (hold) tick();
        set_pin(b, 1'b0);
        repeat (20) tick();
    endtask

    task automatic async_reset(input string tag);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, "_pat"}, 32'(pattern), 1);
        check({tag, "_run"}, 32'(running), 0);
        check({tag, "_spd"}, 32'(speed), 0);
        check({tag, "_stp"}, 32'(step), 0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int pl[3], pt[3], et;
        rst_n = 1'b0; ena = 1'b1; mode = 2'd0;
        pause_btn = 1'b0; faster_btn = 1'b0; slower_btn = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_pat", 32'(pattern), 1);
        check("rst_run", 32'(running), 0);
        check("rst_spd", 32'(speed), 0);
        check("rst_stp", 32'(step), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        // Press latency and first step.
        pause_btn = 1'b1;
        repeat (6) tick();
        check("lat_6", 32'(running), 0);
        tick();
        check("lat_7", 32'(running), 1);
        repeat (13) tick();
        pause_btn = 1'b0;
        repeat (2) tick();
        check("first_pre", 32'(pattern), 1);
        tick();
        check("first_pat", 32'(pattern), 2);
        check("first_stp", 32'(step), 1);
        repeat (60) tick();

        repeat (5) press(1, 20);
        check("fast_sat", 32'(speed), 3);
        repeat (30) tick();
        repeat (4) press(2, 20);
        check("slow_sat", 32'(speed), 0);

        press(0, 3);
        check("glitch", 32'(running), 1);
        press(0, 20);
        check("paused", 32'(running), 0);
        repeat (30) tick();
        press(0, 20);
        check("resumed", 32'(running), 1);

        mode = 2'd1;
        tick();
        check("bnc_seed", 32'(pattern), 1);
        repeat (128) tick();
        mode = 2'd3;
        tick();
        check("gray_seed", 32'(pattern), 0);
        repeat (64) tick();

        press(1, 20);
        faster_btn = 1'b1; slower_btn = 1'b1;
        repeat (20) tick();
        faster_btn = 1'b0; slower_btn = 1'b0;
        repeat (20) tick();
        check("both", 32'(speed), 1);
        repeat (20) tick();

        press(1, 20);
        repeat (5) tick();
        async_reset("ar");
        repeat (3) tick();
        press(0, 20);
        repeat (10) tick();
        ena = 1'b0;
        repeat (40) tick();
        ena = 1'b1;
        repeat (40) tick();

        for (int b = 0; b < 3; b++) begin pl[b] = 0; pt[b] = 0; end
        et = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (pt[b] == 0) begin
                    pl[b] = int'($urandom_range(0, 1));
                    pt[b] = int'($urandom_range(1, 12));
                end else pt[b]--;
                set_pin(b, pl[b] == 1);
            end
            if (et == 0) begin
                ena = $urandom_range(0, 7) != 0;
                et = int'($urandom_range(1, 20));
            end else et--;
            if ($urandom_range(0, 299) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1499) == 0) async_reset("rar");
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/paced_pattern_gen.md
# paced_pattern_gen

Parametrised button-controlled pattern generator for the Tiny Tapeout top level. It debounces pause/faster/slower push-buttons, keeps a run/pause flag and a saturating speed level, and derives a programmable step tick. On each tick it advances a WIDTH-bit output pattern in one of four modes. It sits between `ui_in` (buttons, mode) and `uo_out` (pattern), generalising the fixed-width, single-mode running light.

## Interface
- `WIDTH`, 8, pattern width in bits (>= 2)
- `LEVELS`, 8, number of speed levels (>= 2); level 0 is slowest
- `BASE_DIV`, 50_000_000, clock cycles per step at level 0; must satisfy `BASE_DIV >> (LEVELS-1) >= 1`
- `DEBOUNCE_CYCLES`, 500_000, consecutive stable cycles before a button change is accepted (>= 1)
- `clk`  in  1  system clock; one clock domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `ena`  in  1  global enable; low freezes all state except the input synchronisers
- `pause_btn`  in  1  raw button; each press toggles run/pause
- `faster_btn`  in  1  raw button; each press raises the speed level by 1
- `slower_btn`  in  1  raw button; each press lowers the speed level by 1
- `mode`  in  2  pattern mode: 0 rotate, 1 bounce, 2 binary count, 3 Gray count
- `pattern`  out  WIDTH  current pattern
- `running`  out  1  1 = stepping, 0 = paused
- `speed`  out  clog2(LEVELS)  current speed level
- `step`  out  1  one-cycle pulse in the cycle after each pattern advance

## Operation
- Reset values: `running`=0, `speed`=0, `step`=0, `pattern`=1 (rotate seed), direction=left, prescaler=0, all debounced levels=0, mode register=0.
- Button path, per button: 2-FF synchroniser -> debouncer. The debouncer holds level `db` and counter `cnt`. When sync==db, cnt<=0. Otherwise cnt increments, and when cnt==DEBOUNCE_CYCLES-1, db<=sync and cnt<=0. A press event is the rising edge of `db`; release edges are ignored.
- Pause press: `running` <= ~`running`. The prescaler is held, not cleared, while paused.
- Faster press: `speed` <= min(`speed`+1, LEVELS-1). Slower press: `speed` <= max(`speed`-1, 0).
- Faster and slower events in the same cycle: `speed` unchanged.
- Any actual change of `speed` clears the prescaler. A saturated press clears nothing.
- Period P = BASE_DIV >> `speed`. While `running` and `ena`, the prescaler counts 0..P-1. At P-1 it wraps to 0 and the pattern advances.
- Pattern advance by mode:
  - 0: rotate left by 1, MSB wraps into LSB.
  - 1: bounce a single one. Shift toward the current direction. At bit WIDTH-1 the direction becomes right; at bit 0 it becomes left. The reversal takes effect on the same advance that reaches the end. For WIDTH=4: 0001,0010,0100,1000,0100,0010,0001,0010…
  - 2: internal binary counter +1 mod 2^WIDTH, output directly.
  - 3: the same binary counter +1, output as bin ^ (bin>>1).
- Mode change: `mode` is registered each cycle. When the registered value differs from the new input, the pattern reloads its seed and the prescaler clears.
  - Seeds: modes 0/1 -> `pattern`=1, direction left; modes 2/3 -> counter=0, `pattern`=0.
  - A mode reload takes priority over an advance in the same cycle.
- `ena`=0: debouncers, flags, prescaler, pattern and mode register all hold, and `step`=0.

## Timing
- Press latency: pin rises at edge k. `db` rises at edge k+2+DEBOUNCE_CYCLES. `running`/`speed` update at edge k+3+DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no event.
- Step latency: when `running` rises with the prescaler at 0, the first advance occurs P edges later. `step` is high during the following cycle only.
- Consecutive advances are exactly P cycles apart while the speed is unchanged. At period 1 (P=1), `step` is high every cycle.
- Pause/resume: the prescaler resumes from its held value. Total running cycles between advances stay P.
- Asynchronous reset asserted mid-count or mid-debounce: all state returns to reset values immediately, with no pending event.

## Test plan
Parameters for all scenarios: WIDTH=4, LEVELS=4, BASE_DIV=16, DEBOUNCE_CYCLES=4.
- Reset, then press pause (held 20 cycles) -> `running` rises 7 edges after the pin. First `step` follows 16 cycles later. Mode 0 pattern sequence is 0001,0010,0100,1000,0001.
- Press faster 5 times (each held 20 cycles, then low 20 cycles) -> `speed` goes 1,2,3,3,3. Step spacing goes 16,8,4,2 cycles. Then press slower 4 times -> `speed` goes 2,1,0,0.
- Pulse the pause pin for 3 cycles -> no toggle. A 20-cycle pulse toggles `running`; the prescaler value is held across the pause.
- Mode 1 for 8 steps -> 0001,0010,0100,1000,0100,0010,0001,0010. Switch to mode 3 -> `pattern`=0000, then 0001,0011,0010,0110.
- Faster and slower pins rise in the same cycle with `speed`=1 -> `speed` stays 1 and the prescaler is not cleared.
- Assert `rst_n`=0 mid-period with `running`=1 and `speed`=2 -> all outputs return to reset values asynchronously. `ena`=0 for 40 cycles freezes `pattern` and keeps `step` low.
